// File: rtl/alu_share_arb.sv
// Shared-ALU arbiter: lets NUM_REQ requesters take turns on one combinational
// ALU with valid/ready handshakes. Only one operation is in flight at a time.
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   req_valid_i      per-requester operation pending
//   req_alu_in_i     per-requester operands and opcode
//   req_ready_o      grant, one-hot, combinational in the accepting cycle
//   alu_in_o         operands to the ALU (driven only in EXEC, else zero)
//   alu_res_i/zero_i ALU result and zero flag
//   rsp_valid_o      result valid, one-hot to the owning requester
//   rsp_ready_i      per-requester result consume
//   rsp_data_o/zero_o registered result, held until the owner consumes it
//   busy_o           a transaction is in flight

package alu_share_arb_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } alu_in_t;
endpackage

module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  alu_in_t            req_alu_in_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_o,
  output alu_in_t            alu_in_o,
  input  logic [DATA_W-1:0]  alu_res_i,
  input  logic               alu_zero_i,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  input  logic [NUM_REQ-1:0] rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic               rsp_zero_o,
  output logic               busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  alu_in_t           op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  int unsigned       cand;
  int unsigned       nxt_ptr;
  logic              rsp_hs;
  logic              grant_en;

  // Winner search: rotate from rr_ptr (round-robin) or from 0 (fixed priority)
  always_comb begin : arb
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = RR_EN ? (32'(rr_ptr_q) + off) : off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
    nxt_ptr = 32'(win_idx) + 32'd1;
    if (nxt_ptr >= NUM_REQ) nxt_ptr = 0;
  end

  // A new grant is possible from IDLE, or from RESP in the owner's consume cycle
  assign rsp_hs   = (state_q == S_RESP) && rsp_ready_i[owner_q];
  assign grant_en = win_found && ((state_q == S_IDLE) || rsp_hs);

  // Next-state and output decode
  always_comb begin : fsm
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    alu_in_o    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_en) state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_in_o   = op_q;
        rsp_data_d = alu_res_i;
        rsp_zero_d = alu_zero_i;
        state_d    = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_hs) state_d = win_found ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_en) begin
      req_ready_o[win_idx] = 1'b1;
      op_d                 = req_alu_in_i[win_idx];
      owner_d              = win_idx;
      if (RR_EN) rr_ptr_d  = IDX_W'(nxt_ptr);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_zero_o = rsp_zero_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin instance (dut) and a fixed-priority
// instance (dut_fp), each driven by a small behavioural ALU. Expected results
// are queued at grant time and checked when the response appears.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // round-robin instance signals
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  alu_in_t     req_in [2];
  alu_in_t     alu_in;
  logic [31:0] alu_res, rsp_data;
  logic        alu_zero, rsp_zero, busy;

  // fixed-priority instance signals
  logic [1:0]  fp_valid, fp_ready, fp_rsp_valid, fp_rsp_ready;
  alu_in_t     fp_in [2];
  alu_in_t     fp_alu_in;
  logic [31:0] fp_alu_res, fp_rsp_data;
  logic        fp_alu_zero, fp_rsp_zero, fp_busy;

  typedef struct {
    int unsigned idx;
    logic [31:0] d;
    logic        z;
  } exp_t;
  exp_t sb [$];
  int unsigned exp_rr = 0;

  function automatic logic [32:0] alu_f(alu_in_t x);
    logic [31:0] r;
    case (x.op)
      ALU_ADD:  r = x.a + x.b;
      ALU_SUB:  r = x.a - x.b;
      ALU_AND:  r = x.a & x.b;
      ALU_OR:   r = x.a | x.b;
      ALU_XOR:  r = x.a ^ x.b;
      ALU_SLT:  r = {31'd0, $signed(x.a) < $signed(x.b)};
      ALU_SLTU: r = {31'd0, x.a < x.b};
      default:  r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  always_comb {alu_zero, alu_res} = alu_f(alu_in);
  always_comb {fp_alu_zero, fp_alu_res} = alu_f(fp_alu_in);

  alu_share_arb #(.NUM_REQ(2), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_alu_in_i(req_in), .req_ready_o(req_ready),
    .alu_in_o(alu_in), .alu_res_i(alu_res), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .busy_o(busy)
  );

  alu_share_arb #(.NUM_REQ(2), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(fp_valid), .req_alu_in_i(fp_in), .req_ready_o(fp_ready),
    .alu_in_o(fp_alu_in), .alu_res_i(fp_alu_res), .alu_zero_i(fp_alu_zero),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(fp_rsp_ready),
    .rsp_data_o(fp_rsp_data), .rsp_zero_o(fp_rsp_zero), .busy_o(fp_busy)
  );

  // one cycle forward; inputs are driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; fp_valid = '0; fp_rsp_ready = '0;
    req_in[0] = '0; req_in[1] = '0; fp_in[0] = '0; fp_in[1] = '0;
    repeat (3) tick();
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, busy} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b want 0", req_ready, rsp_valid, busy);
    end
    n_tests++;
    if ({alu_in, rsp_data, rsp_zero} !== '0) begin
      n_fail++; $display("FAIL reset_data: got alu_in=%h data=%h zero=%b want 0", alu_in, rsp_data, rsp_zero);
    end
    n_tests++;
    if ({fp_ready, fp_rsp_valid, fp_busy, fp_rsp_data, fp_rsp_zero} !== '0) begin
      n_fail++; $display("FAIL reset_fp: got ready=%b valid=%b busy=%b data=%h want 0", fp_ready, fp_rsp_valid, fp_busy, fp_rsp_data);
    end
    rst_n = 1'b1;
    exp_rr = 0;
  endtask

  task automatic test_single_op();
    int g_cyc;
    alu_in_t exp_in;
    exp_t e;
    tick();
    req_in[0] = '{a: 32'd5, b: 32'd7, op: ALU_ADD};
    exp_in = req_in[0];
    req_valid = 2'b01; rsp_ready = 2'b01;
    g_cyc = cyc;
    sb.push_back('{idx: 0, d: 32'd12, z: 1'b0});
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, alu_in} !== {2'b01, 2'b00, 68'd0}) begin
      n_fail++; $display("FAIL single_grant: got ready=%b valid=%b alu_in=%h want ready=01 valid=00 alu_in=0", req_ready, rsp_valid, alu_in);
    end
    exp_rr = 1;
    tick();
    req_valid = 2'b00;
    req_in[0] = '{a: 32'd100, b: 32'd100, op: ALU_SUB};
    #1;
    n_tests++;
    if ({busy, req_ready, rsp_valid} !== 5'b1_00_00 || alu_in !== exp_in) begin
      n_fail++; $display("FAIL single_exec: got busy=%b ready=%b valid=%b alu_in=%h want busy=1 alu_in=%h", busy, req_ready, rsp_valid, alu_in, exp_in);
    end
    tick(); #1;
    n_tests++;
    if (cyc - g_cyc != 2 || alu_in !== '0) begin
      n_fail++; $display("FAIL single_latency: got cycles=%0d alu_in=%h want 2 and 0", cyc - g_cyc, alu_in);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL single_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
        n_fail++; $display("FAIL single_rsp: got valid=%b z=%b d=%h want valid=%b z=%b d=%h", rsp_valid, rsp_zero, rsp_data, 2'b01 << e.idx, e.z, e.d);
      end
    end
    tick(); #1;
    n_tests++;
    if ({busy, rsp_valid} !== 3'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%b valid=%b want 0", busy, rsp_valid);
    end
  endtask

  task automatic test_rr_contention();
    int last_c;
    int n_g;
    exp_t e;
    last_c = -1; n_g = 0;
    tick();
    req_in[0] = '{a: 32'd10, b: 32'd20, op: ALU_ADD};
    req_in[1] = '{a: 32'h0000_F0F0, b: 32'h0000_0FF0, op: ALU_XOR};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      req_in[0].b = 32'(k * 3);
      req_in[1].a = 32'(k) << 4;
      #1;
      if (rsp_valid !== 2'b00) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rr_rsp: unexpected valid=%b", rsp_valid);
        end else begin
          e = sb.pop_front();
          if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
            n_fail++; $display("FAIL rr_rsp: got valid=%b z=%b d=%h want valid=%b z=%b d=%h", rsp_valid, rsp_zero, rsp_data, 2'b01 << e.idx, e.z, e.d);
          end
        end
      end
      if (req_ready !== 2'b00) begin
        n_tests++;
        if (req_ready !== (2'b01 << exp_rr)) begin
          n_fail++; $display("FAIL rr_grant: got ready=%b want %b", req_ready, 2'b01 << exp_rr);
        end
        if (last_c >= 0) begin
          n_tests++;
          if (cyc - last_c != 2) begin
            n_fail++; $display("FAIL rr_spacing: got %0d cycles want 2", cyc - last_c);
          end
        end
        e.idx = exp_rr;
        {e.z, e.d} = alu_f(req_in[exp_rr]);
        sb.push_back(e);
        exp_rr = (exp_rr + 1) % 2;
        last_c = cyc; n_g++;
      end
    end
    tick();
    req_valid = 2'b00;
    tick(); #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL rr_last: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
        n_fail++; $display("FAIL rr_last: got valid=%b d=%h want valid=%b d=%h", rsp_valid, rsp_data, 2'b01 << e.idx, e.d);
      end
    end
    n_tests++;
    if (n_g != 7 || sb.size() != 0) begin
      n_fail++; $display("FAIL rr_count: got grants=%0d pending=%0d want 7 and 0", n_g, sb.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    tick();
    req_in[0] = '{a: 32'd3, b: 32'd3, op: ALU_SUB};
    req_valid = 2'b01; rsp_ready = 2'b00;
    sb.push_back('{idx: 0, d: 32'd0, z: 1'b1});
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant: got ready=%b want 01", req_ready);
    end
    exp_rr = 1;
    tick();
    req_valid = 2'b10;
    req_in[1] = '{a: 32'd1, b: 32'd2, op: ALU_ADD};
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL bp_exec_grant: got ready=%b want 00", req_ready);
    end
    for (int s = 0; s < 5; s++) begin
      tick();
      rsp_ready = (s % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      n_tests++;
      if ({busy, req_ready, rsp_valid, rsp_zero, rsp_data} !== {1'b1, 2'b00, 2'b01, 1'b1, 32'd0}) begin
        n_fail++; $display("FAIL bp_hold: got busy=%b ready=%b valid=%b z=%b d=%h want 1 00 01 1 0", busy, req_ready, rsp_valid, rsp_zero, rsp_data);
      end
    end
    tick();
    rsp_ready = 2'b01;
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
        n_fail++; $display("FAIL bp_rsp: got valid=%b z=%b d=%h want valid=%b z=%b d=%h", rsp_valid, rsp_zero, rsp_data, 2'b01 << e.idx, e.z, e.d);
      end
    end
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_b2b_grant: got ready=%b want 10", req_ready);
    end
    sb.push_back('{idx: 1, d: 32'd3, z: 1'b0});
    exp_rr = 0;
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick(); #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_rsp1: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
        n_fail++; $display("FAIL bp_rsp1: got valid=%b z=%b d=%h want valid=%b z=%b d=%h", rsp_valid, rsp_zero, rsp_data, 2'b01 << e.idx, e.z, e.d);
      end
    end
    tick(); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_drop();
    exp_t e;
    tick();
    req_in[0] = '{a: 32'h0000_00F0, b: 32'h0000_000F, op: ALU_OR};
    req_valid = 2'b01; rsp_ready = 2'b00;
    sb.push_back('{idx: 0, d: 32'h0000_00FF, z: 1'b0});
    exp_rr = 1;
    tick();
    req_valid = 2'b10;
    tick();
    tick();
    req_valid = 2'b00; rsp_ready = 2'b01;
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL drop_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, req_ready, rsp_zero, rsp_data} !== {2'b01 << e.idx, 2'b00, e.z, e.d}) begin
        n_fail++; $display("FAIL drop_rsp: got valid=%b ready=%b d=%h want valid=%b ready=00 d=%h", rsp_valid, req_ready, rsp_data, 2'b01 << e.idx, e.d);
      end
    end
    tick(); #1;
    n_tests++;
    if ({busy, req_ready, rsp_valid} !== 5'd0) begin
      n_fail++; $display("FAIL drop_idle: got busy=%b ready=%b valid=%b want 0", busy, req_ready, rsp_valid);
    end
    rsp_ready = 2'b11;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    tick();
    req_in[0] = '{a: 32'd1, b: 32'd1, op: ALU_ADD};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, rsp_valid, alu_in, rsp_data, rsp_zero} !== '0) begin
      n_fail++; $display("FAIL rstmid_now: got busy=%b valid=%b alu_in=%h d=%h want 0", busy, rsp_valid, alu_in, rsp_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      n_tests++;
      if (rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_hold: got valid=%b want 00", rsp_valid);
      end
    end
    rst_n = 1'b1;
    tick();
    req_in[0] = '{a: 32'd40, b: 32'd2, op: ALU_ADD};
    req_in[1] = '{a: 32'd9, b: 32'd9, op: ALU_XOR};
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_ptr: got ready=%b want 01", req_ready);
    end
    sb.push_back('{idx: 0, d: 32'd42, z: 1'b0});
    exp_rr = 1;
    tick();
    req_valid = 2'b00;
    tick(); #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL rstmid_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
        n_fail++; $display("FAIL rstmid_rsp: got valid=%b d=%h want valid=%b d=%h", rsp_valid, rsp_data, 2'b01 << e.idx, e.d);
      end
    end
    tick();
  endtask

  task automatic test_slt();
    alu_in_t ops [2];
    logic [31:0] exp_d [2];
    int unsigned who [2];
    int g_cyc;
    exp_t e;
    ops[0] = '{a: 32'hFFFF_FFFF, b: 32'd1, op: ALU_SLT};
    ops[1] = '{a: 32'hFFFF_FFFF, b: 32'd1, op: ALU_SLTU};
    exp_d[0] = 32'd1; exp_d[1] = 32'd0;
    who[0] = 1; who[1] = 0;
    for (int t = 0; t < 2; t++) begin
      tick();
      req_in[who[t]] = ops[t];
      req_valid = 2'b01 << who[t];
      rsp_ready = 2'b11;
      sb.push_back('{idx: who[t], d: exp_d[t], z: (exp_d[t] == 32'd0)});
      g_cyc = cyc;
      #1;
      n_tests++;
      if (req_ready !== (2'b01 << who[t])) begin
        n_fail++; $display("FAIL slt_grant%0d: got ready=%b want %b", t, req_ready, 2'b01 << who[t]);
      end
      tick();
      req_valid = 2'b00;
      tick(); #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL slt_rsp%0d: scoreboard empty", t);
      end else begin
        e = sb.pop_front();
        if (cyc - g_cyc != 2 || {rsp_valid, rsp_zero, rsp_data} !== {2'b01 << e.idx, e.z, e.d}) begin
          n_fail++; $display("FAIL slt_rsp%0d: got cyc=%0d valid=%b z=%b d=%h want cyc=2 valid=%b z=%b d=%h", t, cyc - g_cyc, rsp_valid, rsp_zero, rsp_data, 2'b01 << e.idx, e.z, e.d);
        end
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    int n_g;
    n_g = 0;
    tick();
    fp_in[0] = '{a: 32'd2, b: 32'd2, op: ALU_ADD};
    fp_in[1] = '{a: 32'd9, b: 32'd9, op: ALU_ADD};
    fp_valid = 2'b11; fp_rsp_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      #1;
      if (fp_ready !== 2'b00) begin
        n_g++;
        n_tests++;
        if (fp_ready !== 2'b01) begin
          n_fail++; $display("FAIL fp_grant: got ready=%b want 01", fp_ready);
        end
      end
      if (fp_rsp_valid !== 2'b00) begin
        n_tests++;
        if ({fp_rsp_valid, fp_rsp_data} !== {2'b01, 32'd4}) begin
          n_fail++; $display("FAIL fp_rsp: got valid=%b d=%h want 01 4", fp_rsp_valid, fp_rsp_data);
        end
      end
    end
    n_tests++;
    if (n_g != 5) begin
      n_fail++; $display("FAIL fp_count: got %0d grants want 5", n_g);
    end
    tick();
    fp_valid = 2'b10;
    #1;
    n_tests++;
    if ({fp_rsp_valid, fp_ready} !== 4'b01_10) begin
      n_fail++; $display("FAIL fp_starve_end: got valid=%b ready=%b want 01 10", fp_rsp_valid, fp_ready);
    end
    tick();
    fp_valid = 2'b00;
    tick(); #1;
    n_tests++;
    if ({fp_rsp_valid, fp_rsp_zero, fp_rsp_data} !== {2'b10, 1'b0, 32'd18}) begin
      n_fail++; $display("FAIL fp_rsp1: got valid=%b z=%b d=%h want 10 0 12", fp_rsp_valid, fp_rsp_zero, fp_rsp_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_rr_contention();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_slt();
    test_fixed_prio();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
